// File: rtl/dyser_output_port_pkg.sv
// dyser_output_port_pkg: fabric path widths, metadata bit indices and the buffered token type
package dyser_output_port_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int META_BITS  = 2;
  localparam int PATH_WIDTH = DATA_WIDTH + META_BITS;
  localparam int META_VALID = 1;
  localparam int META_READY = 0;
  typedef struct packed {
    logic [DATA_WIDTH:0] data;
    logic                pred;
  } token_t;
endpackage

// File: rtl/dyser_output_port_if.sv
// dyser_output_port_if: fabric-side token/credit and host-side pop signals of an output port
interface dyser_output_port_if #(parameter int DEPTH = 4);
  import dyser_output_port_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  logic                conf_en;
  logic [PATH_WIDTH:0] d_in;
  logic                c_out;
  logic [DATA_WIDTH:0] out_data;
  logic                out_pred;
  logic                out_ready;
  logic                pop;
  logic [CW-1:0]       count;
  logic                overflow;
  modport master (output conf_en, d_in, pop, input c_out, out_data, out_pred, out_ready, count, overflow);
  modport slave  (input conf_en, d_in, pop, output c_out, out_data, out_pred, out_ready, count, overflow);
endinterface

// File: rtl/dyser_sync_fifo.sv
// dyser_sync_fifo: synchronous FIFO with count-based full/empty, flush and push-while-full-with-pop
module dyser_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic pop_eff, push_eff;
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);
  assign dout     = empty ? '0 : mem[rp];
  // storage write, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (push_eff) mem[wp] <= din;
  end
  // pointers wrap modulo DEPTH; occupancy tracks push/pop balance
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_eff) wp <= wp + AW'(1);
      if (pop_eff) rp <= rp + AW'(1);
      count <= count + CW'(push_eff) - CW'(pop_eff);
    end
  end
endmodule

// File: rtl/dyser_output_port.sv
// dyser_output_port: buffers fabric tokens for the host and returns one credit per freed slot
module dyser_output_port
  import dyser_output_port_pkg::*;
#(
  parameter int ID           = 0,
  parameter int DEPTH        = 4,
  parameter bit DROP_INVALID = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  dyser_output_port_if.slave  p
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] MAX_CRED = (CW+1)'(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ID < 0) begin : g_bad_param
    $error("dyser_output_port: DEPTH must be a power of 2 >= 2 and ID non-negative");
  end
  token_t tok_in, tok_out;
  logic arrive, drop, push, pop_eff, empty, full;
  logic [CW-1:0] pend, pend_nxt;
  logic [CW:0] cred_sum;
  assign arrive  = p.d_in[META_READY] & ~p.conf_en;
  assign drop    = DROP_INVALID & arrive & ~p.d_in[META_VALID];
  assign push    = arrive & ~drop;
  assign pop_eff = p.pop & ~empty & ~p.conf_en;
  assign tok_in  = '{data: p.d_in[PATH_WIDTH:META_BITS], pred: p.d_in[META_VALID]};
  dyser_sync_fifo #(.WIDTH($bits(token_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (p.conf_en),
    .push  (push),
    .pop   (pop_eff),
    .din   (tok_in),
    .dout  (tok_out),
    .empty (empty),
    .full  (full),
    .count (p.count)
  );
  assign p.out_data  = tok_out.data;
  assign p.out_pred  = tok_out.pred;
  assign p.out_ready = ~empty;
  assign p.c_out     = |pend & ~p.conf_en;
  // one credit leaves per nonzero cycle while pops and dropped invalids add up to two
  always_comb begin
    cred_sum = {1'b0, pend} - (CW+1)'(|pend) + (CW+1)'(pop_eff) + (CW+1)'(drop);
    pend_nxt = cred_sum > MAX_CRED ? CW'(DEPTH) : cred_sum[CW-1:0];
  end
  // pending credit counter, cleared by reset and by configuration
  always_ff @(posedge clk) begin
    if (rst || p.conf_en) pend <= '0;
    else pend <= pend_nxt;
  end
  // sticky flag for a token that found no room and no simultaneous pop
  always_ff @(posedge clk) begin
    if (rst) p.overflow <= 1'b0;
    else if (push && full && !pop_eff) p.overflow <= 1'b1;
  end
endmodule

// File: tb/tb_dyser_output_port.sv
// tb_dyser_output_port: scoreboard bench for the output port FIFO, credit and overflow behaviour
module tb_dyser_output_port;
  import dyser_output_port_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cred_cnt = 0;
  int c0;
  logic [DATA_WIDTH+1:0] exp_q [$];
  logic [DATA_WIDTH+1:0] e;
  logic [3:0] cseq;
  always #5 clk = ~clk;
  dyser_output_port_if #(.DEPTH(4)) ifa ();
  dyser_output_port_if #(.DEPTH(4)) ifb ();
  dyser_output_port #(.ID(0), .DEPTH(4), .DROP_INVALID(1'b1)) dut (.clk(clk), .rst(rst), .p(ifa.slave));
  dyser_output_port #(.ID(1), .DEPTH(4), .DROP_INVALID(1'b0)) dut_b (.clk(clk), .rst(rst), .p(ifb.slave));

  function automatic logic [PATH_WIDTH:0] tok(input logic [DATA_WIDTH:0] d, input logic v);
    return {d, v, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [DATA_WIDTH:0] d);
    ifa.d_in = tok(d, 1'b1);
    exp_q.push_back({d, 1'b1});
    step();
    ifa.d_in = '0;
  endtask

  // monitor: every accepted pop is compared against the scoreboard head; credit pulses are tallied
  always @(negedge clk) begin
    if (!rst && !ifa.conf_en && ifa.pop && ifa.out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", {31'd0, ifa.out_data}, 64'hdead);
      else begin
        e = exp_q.pop_front();
        chk("sb_data", {31'd0, ifa.out_data}, {31'd0, e[DATA_WIDTH+1:1]});
        chk("sb_pred", {63'd0, ifa.out_pred}, {63'd0, e[0]});
      end
    end
    if (ifa.c_out) cred_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    ifa.d_in = '0; ifa.pop = 1'b0; ifa.conf_en = 1'b0;
    ifb.d_in = '0; ifb.pop = 1'b0; ifb.conf_en = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_count", 64'(ifa.count), 0);
    chk("rst_ready", 64'(ifa.out_ready), 0);
    chk("rst_data", 64'(ifa.out_data), 0);
    chk("rst_pred", 64'(ifa.out_pred), 0);
    chk("rst_cout", 64'(ifa.c_out), 0);
    chk("rst_ovf", 64'(ifa.overflow), 0);
    // invalid token is enqueued when dropping is disabled
    ifb.d_in = tok(33'd5, 1'b0);
    step();
    ifb.d_in = '0;
    chk("b_count", 64'(ifb.count), 1);
    chk("b_pred", 64'(ifb.out_pred), 0);
    chk("b_data", 64'(ifb.out_data), 5);
    ifb.pop = 1'b1;
    step();
    ifb.pop = 1'b0;
    chk("b_popped", 64'(ifb.count), 0);
    chk("b_cout", 64'(ifb.c_out), 1);
    step();
    // three back-to-back tokens, no pop
    c0 = cred_cnt;
    for (int i = 1; i <= 3; i++) push_a(33'(i));
    step();
    chk("t1_count", 64'(ifa.count), 3);
    chk("t1_data", 64'(ifa.out_data), 1);
    chk("t1_pred", 64'(ifa.out_pred), 1);
    chk("t1_no_credit", 64'(cred_cnt - c0), 0);
    // fill, then drain one per cycle with credits on consecutive cycles
    push_a(33'd4);
    chk("t2_full", 64'(ifa.count), 4);
    c0 = cred_cnt;
    ifa.pop = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      cseq[k] = ifa.c_out;
    end
    ifa.pop = 1'b0;
    chk("t2_cout_seq", 64'(cseq), 4'hf);
    chk("t2_empty", 64'(ifa.out_ready), 0);
    step();
    chk("t2_cout_end", 64'(ifa.c_out), 0);
    chk("t2_credits", 64'(cred_cnt - c0), 4);
    // push and pop together while full, then overflow
    for (int i = 10; i <= 13; i++) push_a(33'(i));
    chk("t3_full", 64'(ifa.count), 4);
    c0 = cred_cnt;
    ifa.d_in = tok(33'd14, 1'b1);
    exp_q.push_back({33'd14, 1'b1});
    ifa.pop = 1'b1;
    step();
    ifa.d_in = '0; ifa.pop = 1'b0;
    chk("t3_count_same", 64'(ifa.count), 4);
    chk("t3_no_ovf", 64'(ifa.overflow), 0);
    chk("t3_cout", 64'(ifa.c_out), 1);
    step();
    chk("t3_one_credit", 64'(cred_cnt - c0), 1);
    ifa.d_in = tok(33'd15, 1'b1);
    step();
    ifa.d_in = '0;
    chk("t3_ovf", 64'(ifa.overflow), 1);
    chk("t3_ovf_count", 64'(ifa.count), 4);
    ifa.pop = 1'b1;
    repeat (4) step();
    ifa.pop = 1'b0;
    chk("t3_drained", 64'(exp_q.size()), 0);
    step(); step();
    // invalid token dropped on the same edge as a pop: two credits, one slot freed
    push_a(33'd20);
    push_a(33'd21);
    step();
    c0 = cred_cnt;
    ifa.d_in = tok(33'd22, 1'b0);
    ifa.pop = 1'b1;
    step();
    ifa.d_in = '0; ifa.pop = 1'b0;
    chk("t4_count", 64'(ifa.count), 1);
    chk("t4_cout1", 64'(ifa.c_out), 1);
    step();
    chk("t4_cout2", 64'(ifa.c_out), 1);
    step();
    chk("t4_cout3", 64'(ifa.c_out), 0);
    chk("t4_credits", 64'(cred_cnt - c0), 2);
    // configuration flush with two entries and a pending credit
    push_a(33'd23);
    ifa.d_in = tok(33'd24, 1'b1);
    exp_q.push_back({33'd24, 1'b1});
    ifa.pop = 1'b1;
    step();
    ifa.d_in = '0; ifa.pop = 1'b0;
    chk("t5_pre_count", 64'(ifa.count), 2);
    ifa.conf_en = 1'b1;
    ifa.pop = 1'b1;
    ifa.d_in = tok(33'd99, 1'b1);
    c0 = cred_cnt;
    step();
    chk("t5_count", 64'(ifa.count), 0);
    chk("t5_ready", 64'(ifa.out_ready), 0);
    chk("t5_cout", 64'(ifa.c_out), 0);
    step();
    ifa.conf_en = 1'b0; ifa.pop = 1'b0; ifa.d_in = '0;
    exp_q.delete();
    chk("t5_ovf_held", 64'(ifa.overflow), 1);
    chk("t5_count2", 64'(ifa.count), 0);
    chk("t5_no_credit", 64'(cred_cnt - c0), 0);
    push_a(33'd30);
    chk("t5_after_count", 64'(ifa.count), 1);
    chk("t5_after_data", 64'(ifa.out_data), 30);
    // reset mid-stream with two entries and one pending credit
    push_a(33'd31);
    ifa.d_in = tok(33'd32, 1'b1);
    exp_q.push_back({33'd32, 1'b1});
    ifa.pop = 1'b1;
    step();
    ifa.d_in = '0; ifa.pop = 1'b0;
    chk("t6_pre_count", 64'(ifa.count), 2);
    chk("t6_pre_cout", 64'(ifa.c_out), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    c0 = cred_cnt;
    chk("t6_count", 64'(ifa.count), 0);
    chk("t6_ready", 64'(ifa.out_ready), 0);
    chk("t6_data", 64'(ifa.out_data), 0);
    chk("t6_pred", 64'(ifa.out_pred), 0);
    chk("t6_cout", 64'(ifa.c_out), 0);
    chk("t6_ovf", 64'(ifa.overflow), 0);
    step(); step();
    chk("t6_no_credit", 64'(cred_cnt - c0), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
